instr_encoder_loader: RTL

- Reverse direction of the ID-stage instruction field decode.
- Accepts decoded RV32I fields (opcode, rd, funct3, rs1, rs2, funct7, imm) over a valid/ready handshake.
- Packs the fields into a 32-bit instruction word and writes it to the instruction-memory write port at sequential word addresses.
- Used by the bench/boot loader to load programs into IMEM from field-level descriptions.

---
 rtl/instr_encoder_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded RV32I fields into instruction words and streams them into IMEM.
// Optional macro IMM_RANGE_CHECK_EN adds the sticky err_imm immediate-range flag.
module instr_encoder_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 1024,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_end,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_opcode
`ifdef IMM_RANGE_CHECK_EN
  ,
  output logic              err_imm
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] enc;
  logic bad_op, end_pending, accept, last_word;
  assign in_ready = state == LOAD;
  assign imem_we = state == WRITE;
  assign busy = in_ready | imem_we;
  assign done = state == DONE;
  assign accept = in_ready & in_valid;
  assign last_word = word_count + 1'b1 == (ADDR_W+1)'(DEPTH);
  always_comb begin
    enc = NOP_WORD;
    bad_op = 1'b0;
    case (opcode)
      7'b0110011: enc = {funct7, rs2, rs1, funct3, rd, opcode};
      7'b0010011, 7'b0000011, 7'b1100111: enc = {imm[11:0], rs1, funct3, rd, opcode};
      7'b0100011: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      7'b1100011: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      7'b0110111, 7'b0010111: enc = {imm[31:12], rd, opcode};
      7'b1101111: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: bad_op = 1'b1;
    endcase
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = load_start ? LOAD : IDLE;
      LOAD: state_nx = in_valid ? WRITE : load_end ? DONE : LOAD;
      WRITE: state_nx = !imem_ready ? WRITE : (last_word || end_pending || load_end) ? DONE : LOAD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // an accept that coincides with load_end keeps the close request in end_pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      err_opcode <= 1'b0;
      end_pending <= 1'b0;
    end else if (state == IDLE && load_start) begin
      imem_addr <= base_addr;
      word_count <= '0;
      err_opcode <= 1'b0;
      end_pending <= 1'b0;
    end else if (accept) begin
      imem_wdata <= enc;
      err_opcode <= err_opcode | bad_op;
      end_pending <= load_end;
    end else if (state == WRITE) begin
      end_pending <= end_pending | load_end;
      if (imem_ready) begin
        imem_addr <= imem_addr + 1'b1;
        word_count <= word_count + 1'b1;
      end
    end
  end
`ifdef IMM_RANGE_CHECK_EN
  logic imm_bad;
  always_comb begin
    imm_bad = 1'b0;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011: imm_bad = imm[31:11] != {21{imm[11]}};
      7'b1100011: imm_bad = imm[0] || imm[31:12] != {20{imm[12]}};
      7'b1101111: imm_bad = imm[0] || imm[31:20] != {12{imm[20]}};
      7'b0110111, 7'b0010111: imm_bad = |imm[11:0];
      default: imm_bad = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_imm <= 1'b0;
    else if (state == IDLE && load_start) err_imm <= 1'b0;
    else if (accept) err_imm <= err_imm | imm_bad;
`endif
endmodule
